// File: rtl/ex_divider.sv
// ex_divider: multi-cycle restoring radix-2 divider for DIV/DIVU in EX.
// Stalls the pipeline while iterating and delivers quotient (LO) and
// remainder (HI) with a one-cycle done pulse. A flush aborts silently.
module ex_divider #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_request,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned SR_W  = 2 * DATA_WIDTH + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIVIDING = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]       state,     state_nx;
  logic [CNT_W-1:0] counter,   counter_nx;
  logic [SR_W-1:0]  shift_q,   shift_nx;
  logic [W-1:0]     div_mag,   div_mag_nx;
  logic             neg_q,     neg_q_nx;
  logic             neg_r,     neg_r_nx;
  logic             done_nx;
  logic [W-1:0]     quotient_nx, remainder_nx;

  // Operand magnitudes and signs at the point of acceptance.
  logic         a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  // One restoring iteration of the {rem,quo} shift register.
  logic [SR_W-1:0] shifted;
  logic [W+1:0]    trial;
  logic [SR_W-1:0] step_val;
  logic [W-1:0]    q_mag, r_mag, q_fix, r_fix;
  logic            last_iter;

  // Operand sign/magnitude extraction.
  always_comb begin
    a_neg = signed_div & dividend[W-1];
    b_neg = signed_div & divisor[W-1];
    a_mag = a_neg ? (~dividend + W'(1)) : dividend;
    b_mag = b_neg ? (~divisor + W'(1)) : divisor;
  end

  // Shift-subtract step and sign correction of the final result.
  always_comb begin
    shifted  = shift_q << 1;
    trial    = {1'b0, shifted[SR_W-1:W]} - {2'b00, div_mag};
    step_val = trial[W+1] ? shifted : {trial[W:0], shifted[W-1:1], 1'b1};
    q_mag    = step_val[W-1:0];
    r_mag    = step_val[2*W-1:W];
    q_fix    = neg_q ? (~q_mag + W'(1)) : q_mag;
    r_fix    = neg_r ? (~r_mag + W'(1)) : r_mag;
    last_iter = (counter == CNT_W'(W - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    counter_nx   = counter;
    shift_nx     = shift_q;
    div_mag_nx   = div_mag;
    neg_q_nx     = neg_q;
    neg_r_nx     = neg_r;
    done_nx      = 1'b0;
    quotient_nx  = quotient;
    remainder_nx = remainder;

    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg_q_nx   = a_neg ^ b_neg;
            neg_r_nx   = a_neg;
            div_mag_nx = b_mag;
            shift_nx   = {{(W + 1){1'b0}}, a_mag};
            counter_nx = '0;
            if (divisor == '0) begin
              // Divide by zero completes immediately with raw dividend.
              state_nx     = DONE;
              done_nx      = 1'b1;
              quotient_nx  = '1;
              remainder_nx = dividend;
            end else begin
              state_nx = DIVIDING;
            end
          end
        end
        DIVIDING: begin
          shift_nx   = step_val;
          counter_nx = counter + CNT_W'(1);
          if (last_iter) begin
            state_nx     = DONE;
            done_nx      = 1'b1;
            quotient_nx  = q_fix;
            remainder_nx = r_fix;
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      shift_q   <= '0;
      div_mag   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nx;
      counter   <= counter_nx;
      shift_q   <= shift_nx;
      div_mag   <= div_mag_nx;
      neg_q     <= neg_q_nx;
      neg_r     <= neg_r_nx;
      done      <= done_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
    end
  end

  // Hold the pipeline while a division is being accepted or iterating.
  assign stall_request = !flush && (((state == IDLE) && start) || (state == DIVIDING));

endmodule

// File: tb/tb_ex_divider.sv
// Scoreboard bench for ex_divider: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_ex_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         stall_request;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  int           n_checks = 0;
  int           n_fails = 0;
  int           cyc = 0;

  ex_divider #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .start         (start),
    .signed_div    (signed_div),
    .dividend      (dividend),
    .divisor       (divisor),
    .stall_request (stall_request),
    .done          (done),
    .quotient      (quotient),
    .remainder     (remainder)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural corner cases.
  function automatic exp_t model(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, lq, lr;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (sd) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      lq  = sa / sb_;
      lr  = sa % sb_;
      e.q = 32'(lq);
      e.r = 32'(lr);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL spurious_done: done=1 with no outstanding division, expected done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        last_q = mon_e.q;
        last_r = mon_e.r;
      end
    end
  end

  // Issue one division and track stall/done timing until completion.
  task automatic run_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit keep_start);
    int s;
    int lat;
    bit seen;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    s = cyc;
    sb.push_back(model(sd, a, b));
    lat = (b == '0) ? 1 : int'(W) + 1;
    seen = 1'b0;
    for (int k = 0; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("done_latency", 32'(cyc - s), 32'(lat));
        check("stall_in_done", 32'(stall_request), 32'd0);
      end else begin
        check("stall_busy", 32'(stall_request), 32'd1);
      end
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL done_timeout: no done within 40 cycles of start at cycle %0d, expected done at +%0d", s, lat);
    end
    if (!keep_start) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // DIVU 100/7 flushed at cycle 10, then start+flush together at cycle 11.
  task automatic flush_test();
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    check("flush_stall_c0", 32'(stall_request), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) flush = 1'b1;
      @(negedge clk);
      check("flush_stall", 32'(stall_request), (k < 10) ? 32'd1 : 32'd0);
      check("flush_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    check("flush_prio_stall", 32'(stall_request), 32'd0);
    check("flush_prio_done", 32'(done), 32'd0);
    check("flush_hold_q", quotient, last_q);
    check("flush_hold_r", remainder, last_r);
  endtask

  // Reset asserted at cycle 20 of a division discards it.
  task automatic reset_test();
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 20) begin
        rst = 1'b0;
        start = 1'b0;
      end else begin
        @(negedge clk);
        check("rst_stall_busy", 32'(stall_request), 32'd1);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_q", quotient, 32'd0);
    check("rst_mid_r", remainder, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_stall", 32'(stall_request), 32'd0);
    last_q = '0;
    last_r = '0;
  endtask

  function automatic logic [W-1:0] pick_operand(input int sel);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(1 + $urandom_range(0, 15));
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_stall", 32'(stall_request), 32'd0);
    rst = 1'b1;
    idle(2);

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    idle(1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

    flush_test();
    run_div(1'b0, 32'd100, 32'd7, 1'b0);

    run_div(1'b0, 32'd1234, 32'd5, 1'b1);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

    reset_test();
    run_div(1'b0, 32'd50, 32'd6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic         sd;
      logic [W-1:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a  = pick_operand(int'($urandom_range(0, 9)));
      b  = pick_operand(int'($urandom_range(0, 9)));
      run_div(sd, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
